// File: rtl/midi_pkg.sv
// Shared types, status-byte constants and the message-length lookup for the
// MIDI receive path.
package midi_pkg;

   typedef enum logic [1:0] {
      P_WAIT_STATUS,
      P_WAIT_D1,
      P_WAIT_D2,
      P_SYSEX
   } parser_state_t;

   typedef enum logic [2:0] {
      U_IDLE,
      U_START,
      U_DATA,
      U_STOP,
      U_WAIT_HIGH
   } uart_state_t;

   localparam logic [7:0] CHAN_LO     = 8'h80;
   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] TUNE_REQ    = 8'hF6;
   localparam logic [7:0] RT_LO       = 8'hF8;

   // Data bytes that follow a status byte; 0 for anything carrying no payload.
   function automatic logic [1:0] data_len(input logic [7:0] s);
      logic [1:0] n;
      n = 2'd0;
      if (s >= 8'h80 && s <= 8'hBF)      n = 2'd2;
      else if (s >= 8'hC0 && s <= 8'hDF) n = 2'd1;
      else if (s >= 8'hE0 && s <= 8'hEF) n = 2'd2;
      else if (s == 8'hF1 || s == 8'hF3) n = 2'd1;
      else if (s == 8'hF2)               n = 2'd2;
      return n;
   endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Message/realtime output bundle of the MIDI receiver, plus FSM debug state.
// Strobes only: msg_valid/rt_valid/framing_err pulse for one cycle with no ready;
// the slave must capture on the strobe, payload holds until the next strobe.
interface midi_rx_parser_if;
   import midi_pkg::*;

   logic [7:0]    status;
   logic [7:0]    data1;
   logic [7:0]    data2;
   logic [1:0]    bytes_cnt;
   logic          msg_valid;
   logic [7:0]    rt_byte;
   logic          rt_valid;
   logic          framing_err;
   parser_state_t pstate;
   uart_state_t   ustate;

   modport master (
      output status, data1, data2, bytes_cnt, msg_valid,
      output rt_byte, rt_valid, framing_err, pstate, ustate
   );

   modport slave (
      input status, data1, data2, bytes_cnt, msg_valid,
      input rt_byte, rt_valid, framing_err, pstate, ustate
   );

endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: 2-FF synchroniser, mid-bit sampling, framing check.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 3200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        midi_rx,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        framing_err,
   output uart_state_t dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync_q;
   logic          rx_s;
   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= U_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], midi_rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      case (state_q)
         U_IDLE: if (!rx_s) begin
            state_d = U_START;
            cnt_d   = HALF;
         end
         U_START: if (cnt_q == '0) begin
            state_d = rx_s ? U_IDLE : U_DATA;
            cnt_d   = FULL;
            bit_d   = '0;
         end else cnt_d = cnt_q - 1'b1;
         U_DATA: if (cnt_q == '0) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            cnt_d   = FULL;
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = U_STOP;
         end else cnt_d = cnt_q - 1'b1;
         U_STOP: if (cnt_q == '0) begin
            state_d = rx_s ? U_IDLE : U_WAIT_HIGH;
         end else cnt_d = cnt_q - 1'b1;
         U_WAIT_HIGH: if (rx_s) state_d = U_IDLE;
         default: state_d = U_IDLE;
      endcase
   end

   always_comb begin
      byte_out    = shreg_q;
      byte_valid  = (state_q == U_STOP) && (cnt_q == '0) && rx_s;
      framing_err = (state_q == U_STOP) && (cnt_q == '0) && !rx_s;
      dbg_state   = state_q;
   end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI input stage: deserialises bytes and assembles channel/system-common
// messages with running status, SysEx skipping and realtime pass-through.
module midi_rx_parser
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 3200
) (
   input  logic clk,
   input  logic rst,
   input  logic midi_rx,
   midi_rx_parser_if.master bus
);

   logic [7:0]  rx_byte;
   logic        byte_valid;
   logic        uart_ferr;
   uart_state_t ustate;

   midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk        (clk),
      .rst        (rst),
      .midi_rx    (midi_rx),
      .byte_out   (rx_byte),
      .byte_valid (byte_valid),
      .framing_err(uart_ferr),
      .dbg_state  (ustate)
   );

   parser_state_t pstate_q, pstate_d;
   logic [7:0] run_status_q, run_status_d;
   logic       run_valid_q, run_valid_d;
   logic [7:0] cur_status_q, cur_status_d;
   logic [7:0] d1_q, d1_d;
   logic [7:0] status_q, status_d, data1_q, data1_d, data2_q, data2_d;
   logic [1:0] cnt_q, cnt_d;
   logic       msg_valid_q, msg_valid_d;
   logic [7:0] rt_byte_q, rt_byte_d;
   logic       rt_valid_q, rt_valid_d, ferr_q, ferr_d;
   logic [7:0] first_status;

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate_q     <= P_WAIT_STATUS;
         run_status_q <= '0;
         run_valid_q  <= 1'b0;
         cur_status_q <= '0;
         d1_q         <= '0;
         status_q     <= '0;
         data1_q      <= '0;
         data2_q      <= '0;
         cnt_q        <= '0;
         msg_valid_q  <= 1'b0;
         rt_byte_q    <= '0;
         rt_valid_q   <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         pstate_q     <= pstate_d;
         run_status_q <= run_status_d;
         run_valid_q  <= run_valid_d;
         cur_status_q <= cur_status_d;
         d1_q         <= d1_d;
         status_q     <= status_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         cnt_q        <= cnt_d;
         msg_valid_q  <= msg_valid_d;
         rt_byte_q    <= rt_byte_d;
         rt_valid_q   <= rt_valid_d;
         ferr_q       <= ferr_d;
      end
   end

   always_comb begin
      pstate_d     = pstate_q;
      run_status_d = run_status_q;
      run_valid_d  = run_valid_q;
      cur_status_d = cur_status_q;
      d1_d         = d1_q;
      status_d     = status_q;
      data1_d      = data1_q;
      data2_d      = data2_q;
      cnt_d        = cnt_q;
      msg_valid_d  = 1'b0;
      rt_byte_d    = rt_byte_q;
      rt_valid_d   = 1'b0;
      ferr_d       = uart_ferr;
      // A data byte in WAIT_STATUS reuses the running status as its header.
      first_status = (pstate_q == P_WAIT_STATUS) ? run_status_q : cur_status_q;
      if (byte_valid) begin
         if (rx_byte >= RT_LO) begin
            rt_byte_d  = rx_byte;
            rt_valid_d = 1'b1;
         end else if (rx_byte >= CHAN_LO) begin
            if (rx_byte == SYSEX_END) begin
               if (pstate_q == P_SYSEX) pstate_d = P_WAIT_STATUS;
            end else if (rx_byte < SYSEX_START) begin
               run_status_d = rx_byte;
               run_valid_d  = 1'b1;
               cur_status_d = rx_byte;
               pstate_d     = P_WAIT_D1;
            end else begin
               run_valid_d = 1'b0;
               pstate_d    = P_WAIT_STATUS;
               if (rx_byte == SYSEX_START) begin
                  pstate_d = P_SYSEX;
               end else if (rx_byte == TUNE_REQ) begin
                  status_d    = rx_byte;
                  data1_d     = '0;
                  data2_d     = '0;
                  cnt_d       = 2'd1;
                  msg_valid_d = 1'b1;
               end else if (data_len(rx_byte) != 2'd0) begin
                  cur_status_d = rx_byte;
                  pstate_d     = P_WAIT_D1;
               end
            end
         end else if (pstate_q == P_WAIT_D2) begin
            status_d    = cur_status_q;
            data1_d     = d1_q;
            data2_d     = rx_byte;
            cnt_d       = 2'd3;
            msg_valid_d = 1'b1;
            pstate_d    = P_WAIT_STATUS;
         end else if (pstate_q == P_WAIT_D1 ||
                      (pstate_q == P_WAIT_STATUS && run_valid_q)) begin
            cur_status_d = first_status;
            if (data_len(first_status) == 2'd1) begin
               status_d    = first_status;
               data1_d     = rx_byte;
               data2_d     = '0;
               cnt_d       = 2'd2;
               msg_valid_d = 1'b1;
               pstate_d    = P_WAIT_STATUS;
            end else begin
               d1_d     = rx_byte;
               pstate_d = P_WAIT_D2;
            end
         end
      end
   end

   always_comb begin
      bus.status      = status_q;
      bus.data1       = data1_q;
      bus.data2       = data2_q;
      bus.bytes_cnt   = cnt_q;
      bus.msg_valid   = msg_valid_q;
      bus.rt_byte     = rt_byte_q;
      bus.rt_valid    = rt_valid_q;
      bus.framing_err = ferr_q;
      bus.pstate      = pstate_q;
      bus.ustate      = ustate;
   end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Randomised and directed bench for midi_rx_parser with a byte-level message
// model feeding expected queues that a free-running monitor drains.
module tb_midi_rx_parser;
   import midi_pkg::*;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic midi_rx = 1'b1;

   midi_rx_parser_if bus();

   midi_rx_parser #(.CLKS_PER_BIT(CPB)) dut (
      .clk    (clk),
      .rst    (rst),
      .midi_rx(midi_rx),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int ferr_seen = 0;
   int ferr_exp = 0;

   logic [25:0] exp_q[$];
   logic [7:0]  rt_q[$];

   // Reference model state: bytes of the message being gathered.
   logic [7:0] mbuf[$];
   int         run_st = -1;
   bit         in_sx = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic int need(input logic [7:0] s);
      case (s[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2;
         4'hC, 4'hD: return 1;
         4'hF: begin
            if (s == 8'hF2) return 2;
            if (s == 8'hF1 || s == 8'hF3) return 1;
            return 0;
         end
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      run_st = -1;
      in_sx  = 1'b0;
      mbuf.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [7:0] d1, d2;
      if (b >= 8'hF8) begin
         rt_q.push_back(b);
         return;
      end
      if (b[7]) begin
         if (b == 8'hF7) begin
            in_sx = 1'b0;
            return;
         end
         in_sx = 1'b0;
         mbuf.delete();
         if (b < 8'hF0) begin
            run_st = int'(b);
            mbuf.push_back(b);
         end else begin
            run_st = -1;
            if (b == 8'hF0) in_sx = 1'b1;
            else if (b == 8'hF6) exp_q.push_back({8'hF6, 8'h00, 8'h00, 2'd1});
            else if (need(b) > 0) mbuf.push_back(b);
         end
         return;
      end
      if (in_sx) return;
      if (mbuf.size() == 0) begin
         if (run_st < 0) return;
         mbuf.push_back(8'(run_st));
      end
      mbuf.push_back(b);
      if (mbuf.size() == 1 + need(mbuf[0])) begin
         d1 = mbuf[1];
         d2 = (mbuf.size() > 2) ? mbuf[2] : 8'h00;
         exp_q.push_back({mbuf[0], d1, d2, 2'(mbuf.size())});
         mbuf.delete();
      end
   endfunction

   task automatic line_bit(input logic v);
      midi_rx = v;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_raw(input logic [7:0] b, input logic stop);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
      line_bit(stop);
      if (!stop) line_bit(1'b1);
   endtask

   task automatic send(input logic [7:0] b);
      model_byte(b);
      send_raw(b, 1'b1);
   endtask

   task automatic drain();
      repeat (CPB * 4) @(posedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      @(negedge clk);
      check({tag, "_status"}, 32'(bus.status), 32'h0);
      check({tag, "_data1"}, 32'(bus.data1), 32'h0);
      check({tag, "_data2"}, 32'(bus.data2), 32'h0);
      check({tag, "_bytes_cnt"}, 32'(bus.bytes_cnt), 32'h0);
      check({tag, "_msg_valid"}, 32'(bus.msg_valid), 32'h0);
      check({tag, "_rt_byte"}, 32'(bus.rt_byte), 32'h0);
      check({tag, "_rt_valid"}, 32'(bus.rt_valid), 32'h0);
      check({tag, "_framing_err"}, 32'(bus.framing_err), 32'h0);
      check({tag, "_pstate"}, 32'(bus.pstate), 32'(P_WAIT_STATUS));
   endtask

   // Monitor: every strobe is matched against the head of its expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.msg_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_msg: got %h %h %h %0d expected none",
                        bus.status, bus.data1, bus.data2, bus.bytes_cnt);
            end else begin
               check("msg", 32'({bus.status, bus.data1, bus.data2, bus.bytes_cnt}),
                     32'(exp_q.pop_front()));
            end
         end
         if (bus.rt_valid) begin
            if (rt_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_rt: got %h expected none", bus.rt_byte);
            end else begin
               check("rt_byte", 32'(bus.rt_byte), 32'(rt_q.pop_front()));
            end
         end
         if (bus.msg_valid && bus.rt_valid) begin
            compared++;
            mismatched++;
            $display("FAIL strobe_excl: got both strobes expected one");
         end
         if (bus.framing_err) ferr_seen++;
      end
   end

   initial begin
      int kind;
      int n;
      logic [7:0] pb;
      logic [7:0] sc[6];
      sc[0] = 8'hF1; sc[1] = 8'hF2; sc[2] = 8'hF3;
      sc[3] = 8'hF4; sc[4] = 8'hF5; sc[5] = 8'hF6;

      rst = 1'b1;
      repeat (4) @(posedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      model_reset();

      // Note On, running status, program change, realtime interleave
      send(8'h90); send(8'h3C); send(8'h64);
      send(8'h3E); send(8'h70);
      send(8'hC0); send(8'h42);
      send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
      drain();

      // Framing error: the bad byte never reaches the parser
      ferr_exp++;
      send_raw(8'h90, 1'b0);
      drain();
      @(negedge clk);
      check("ferr_pstate", 32'(bus.pstate), 32'(P_WAIT_STATUS));
      check("ferr_count", 32'(ferr_seen), 32'(ferr_exp));
      send(8'hC5); send(8'h11);

      // SysEx then a stray data byte with no running status
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C);
      drain();

      // Reset during data bit 4 of a byte that would complete a message
      send(8'h90); send(8'h3C);
      pb = 8'h64;
      line_bit(1'b0);
      for (int i = 0; i < 4; i++) line_bit(pb[i]);
      midi_rx = pb[4];
      repeat (CPB / 2) @(posedge clk);
      rst = 1'b1;
      midi_rx = 1'b1;
      repeat (3) @(posedge clk);
      check_zero_outputs("midreset");
      rst = 1'b0;
      model_reset();
      repeat (CPB) @(posedge clk);
      send(8'hB0); send(8'h2E); send(8'h7F);

      // Randomised byte stream
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 99);
         if (kind < 18) begin
            send(8'($urandom_range(8'hF8, 8'hFF)));
         end else if (kind < 33) begin
            send(8'($urandom_range(8'h80, 8'hEF)));
         end else if (kind < 40) begin
            send(sc[$urandom_range(0, 5)]);
         end else if (kind < 45) begin
            send(8'hF0);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) send(8'($urandom_range(0, 127)));
            send(8'hF7);
         end else begin
            send(8'($urandom_range(0, 127)));
         end
      end

      drain();
      repeat (CPB * 12) @(posedge clk);
      @(negedge clk);
      check("msg_queue_empty", 32'(exp_q.size()), 32'h0);
      check("rt_queue_empty", 32'(rt_q.size()), 32'h0);
      check("ferr_total", 32'(ferr_seen), 32'(ferr_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
